sub_8bit_sat_stage: RTL



---
 rtl/sub_8bit_sat_stage_if.sv | 22 ++
 rtl/sub_8bit_sat_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sub_8bit_sat_stage_if.sv
// Handshake bundle between the subtractor, the saturation stage and its consumer.
// The slave modport is the stage side; the master modport drives words in and sinks them out.
interface sub_8bit_sat_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_diff;
  logic       in_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;

  modport slave (
    input  in_valid, in_diff, in_ovf, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_diff, in_ovf, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sub_8bit_sat_stage.sv
// Saturating output stage for the 8-bit subtractor, overflow counter + sticky (saturation under SUB_SAT_EN).
// Latency: 1 cycle from accept to out_valid; 1 word/cycle sustained.
// Backpressure: 2-entry skid (main + skid); in_ready is registered and drops only when both are full.
module sub_8bit_sat_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sub_8bit_sat_stage_if.slave bus,
  input  logic             clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             ovf_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       in_ready_q;
  logic [7:0] main_data;
  logic       main_ovf;
  logic [7:0] skid_data;
  logic       skid_ovf;
  logic [7:0] sat_diff;
  logic       acc;
  logic       emit;
  logic       ovf_acc;
  logic       load_main;
  logic       load_skid;
  logic       skid_to_main;

  assign acc           = bus.in_valid && in_ready_q;
  assign emit          = bus.out_valid && bus.out_ready;
  assign ovf_acc       = acc && bus.in_ovf;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_data;
  assign bus.out_ovf   = main_ovf;

`ifdef SUB_SAT_EN
  // A wrapped negative-looking difference with overflow means the true result was positive.
  always_comb begin
    sat_diff = bus.in_diff;
    if (bus.in_ovf) begin
      sat_diff = bus.in_diff[7] ? 8'h7F : 8'h80;
    end
  end
`else
  assign sat_diff = bus.in_diff;
`endif

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (acc && emit) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (emit) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_nxt    = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= 8'h00;
      main_ovf   <= 1'b0;
      skid_data  <= 8'h00;
      skid_ovf   <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (load_main) begin
        main_data <= sat_diff;
        main_ovf  <= bus.in_ovf;
      end else if (skid_to_main) begin
        main_data <= skid_data;
        main_ovf  <= skid_ovf;
      end
      if (load_skid) begin
        skid_data <= sat_diff;
        skid_ovf  <= bus.in_ovf;
      end
    end
  end

  // clr wins over the old count but not over an overflow accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      ovf_cnt    <= ovf_acc ? CNT_ONE : '0;
      ovf_sticky <= ovf_acc;
    end else if (ovf_acc) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != CNT_MAX) begin
        ovf_cnt <= ovf_cnt + CNT_ONE;
      end
    end
  end

endmodule
